// File: rtl/rx_ins_sched.sv
// rx_ins_sched: instruction scheduler in front of the rx configuration stage.
//
// Two requesters (src0 = main stream, src1 = prefetch stream) push
// instructions into a small in-order queue through a round-robin arbiter.
// The head of the queue is issued on the out_* port once no instruction of
// the same type is still outstanding. The rx configuration stage reports
// completions through done_pulse/done_type, which clear the busy flags.
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   src0_valid/ready/ins         requester 0 (main instruction stream)
//   src1_valid/ready/ins         requester 1 (prefetch stream)
//   out_valid/ready/ins          issue port to the rx configuration stage
//   done_pulse, done_type[3:0]   completion report, type bits {i,d,p,a}
//   busy[3:0]                    outstanding flags per type {i,d,p,a}
//   fifo_cnt                     queue occupancy
//   idle                         queue empty, nothing outstanding, FSM idle
//   err                          sticky watchdog error
//
// Optional feature: define RX_SCHED_TIMEOUT_EN to enable the watchdog that
// raises err when busy stays non-zero for TIMEOUT_CYC cycles without a
// completion. Without it err is tied low.
//
// Opcode encodings (bits [61:58]): RD_OP_DW=4'h1, RD_OP_D=4'h2, RD_OP_G=4'h3.
// FIFO_DEPTH must be a power of two, at least 2. INST_W must be at least 62.

module rx_ins_sched #(
  parameter int INST_W      = 64,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          src0_valid,
  output logic                          src0_ready,
  input  logic [INST_W-1:0]             src0_ins,
  input  logic                          src1_valid,
  output logic                          src1_ready,
  input  logic [INST_W-1:0]             src1_ins,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INST_W-1:0]             out_ins,
  input  logic                          done_pulse,
  input  logic [3:0]                    done_type,
  output logic [3:0]                    busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          idle,
  output logic                          err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [3:0] RD_OP_DW = 4'h1;
  localparam logic [3:0] RD_OP_D  = 4'h2;
  localparam logic [3:0] RD_OP_G  = 4'h3;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ISSUE} state_t;

  state_t            state_q, state_d;
  logic [INST_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              rr_ptr;
  logic              winner;
  logic              full, empty, push, pop, load_out;
  logic [INST_W-1:0] push_ins, head_ins;
  logic [3:0]        head_type;

  // Completion type of an opcode; RD_OP_DW occupies both i and p slots.
  function automatic logic [3:0] ins_type(input logic [3:0] op);
    logic [3:0] t;
    case (op)
      RD_OP_DW:         t = 4'b1010;
      RD_OP_D, RD_OP_G: t = 4'b0100;
      default:          t = 4'b0001;
    endcase
    return t;
  endfunction

  // The extra pointer bit tells a full queue apart from an empty one.
  assign fifo_cnt  = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_ins  = mem[rd_ptr[AW-1:0]];
  assign head_type = ins_type(head_ins[61:58]);

  // A lone valid source always wins; on contention, or with nobody
  // requesting, the round-robin pointer decides.
  always_comb begin
    winner = rr_ptr;
    if (src0_valid && !src1_valid) begin
      winner = 1'b0;
    end else if (src1_valid && !src0_valid) begin
      winner = 1'b1;
    end
  end

  assign src0_ready = rst_n && !full && !winner;
  assign src1_ready = rst_n && !full && winner;
  assign push       = (src0_valid && src0_ready) || (src1_valid && src1_ready);
  assign push_ins   = winner ? src1_ins : src0_ins;

  assign idle = (state_q == S_IDLE) && empty && (busy == 4'b0000);

  // Issue control. The head is copied into out_ins when leaving S_CHECK so
  // the issue port holds a stable value for the whole S_ISSUE stay.
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    load_out  = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((busy & head_type) == 4'b0000) begin
          state_d  = S_ISSUE;
          load_out = 1'b1;
        end
      end
      S_ISSUE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pop = 1'b1;
          if (fifo_cnt > (AW+1)'(1) || push) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Queue storage needs no reset; only pointers define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= push_ins;
    end
  end

  // State, pointers and busy tracking. A busy bit set by an issue takes
  // precedence over a completion for the same type in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rr_ptr  <= 1'b0;
      busy    <= 4'b0000;
      out_ins <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= ~rr_ptr;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (load_out) begin
        out_ins <= head_ins;
      end
      busy <= (busy & ~(done_pulse ? done_type : 4'b0000)) |
              (pop ? head_type : 4'b0000);
    end
  end

`ifdef RX_SCHED_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // Watchdog: counts cycles with work outstanding and no completion seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (busy == 4'b0000 || done_pulse) begin
        wd_cnt <= '0;
      end else if (wd_cnt != 16'hFFFF) begin
        wd_cnt <= wd_cnt + 16'd1;
      end
      if (wd_cnt == 16'(TIMEOUT_CYC)) begin
        err <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_ins_sched.sv
// tb_rx_ins_sched: self-checking bench for rx_ins_sched.
// A queue-based reference model predicts every registered output each cycle;
// directed sequences add explicit expectations for the key scenarios.

module tb_rx_ins_sched;

  localparam logic [3:0] OP_DW = 4'h1;
  localparam logic [3:0] OP_D  = 4'h2;
  localparam logic [3:0] OP_G  = 4'h3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        src0_valid = 1'b0, src1_valid = 1'b0;
  logic        src0_ready, src1_ready;
  logic [63:0] src0_ins = '0, src1_ins = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_ins;
  logic        done_pulse = 1'b0;
  logic [3:0]  done_type = 4'b0000;
  logic [3:0]  busy;
  logic [2:0]  fifo_cnt;
  logic        idle, err;

  int total = 0;
  int bad   = 0;

  // Reference model: queued instructions in order, outstanding type flags,
  // whether the head is being offered, and the earliest cycle at which the
  // head may be checked for hazards.
  logic [63:0] mq[$];
  logic [3:0]  m_busy;
  logic        m_valid;
  logic        m_rr;
  int          m_avail;
  int          cyc;

  logic [63:0] insA, insB;

  rx_ins_sched #(.INST_W(64), .FIFO_DEPTH(4), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_ins(src0_ins),
    .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_ins(src1_ins),
    .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins),
    .done_pulse(done_pulse), .done_type(done_type),
    .busy(busy), .fifo_cnt(fifo_cnt), .idle(idle), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] typeOf(input logic [63:0] ins);
    if (ins[61:58] == OP_DW) return 4'b1010;
    if (ins[61:58] == OP_D || ins[61:58] == OP_G) return 4'b0100;
    return 4'b0001;
  endfunction

  function automatic logic [63:0] mkIns(input logic [3:0] op);
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[61:58] = op;
    return r;
  endfunction

  function automatic logic [3:0] randOp();
    case ($urandom_range(0, 3))
      0:       return OP_DW;
      1:       return OP_D;
      2:       return OP_G;
      default: return 4'($urandom_range(4, 15));
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, compare the DUT with
  // the model, then advance the model to what the next cycle should show.
  task automatic applyStimulus(input logic v0, input logic [63:0] i0,
                               input logic v1, input logic [63:0] i1,
                               input logic ordy, input logic dp,
                               input logic [3:0] dt);
    int         sz;
    logic       full, win, push, pop, nvalid;
    logic [3:0] ht, nb;
    @(negedge clk);
    src0_valid = v0; src0_ins = i0;
    src1_valid = v1; src1_ins = i1;
    out_ready = ordy; done_pulse = dp; done_type = dt;
    #1;
    sz   = mq.size();
    full = (sz == 4);
    if (v0 && !v1)      win = 1'b0;
    else if (v1 && !v0) win = 1'b1;
    else                win = m_rr;
    ht = (sz > 0) ? typeOf(mq[0]) : 4'b0000;

    checkOutput("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) checkOutput("out_ins", out_ins, mq[0]);
    checkOutput("busy", 64'(busy), 64'(m_busy));
    checkOutput("fifo_cnt", 64'(fifo_cnt), 64'(sz));
    checkOutput("idle", 64'(idle), 64'(sz == 0 && m_busy == 4'b0000));
    checkOutput("src0_ready", 64'(src0_ready), 64'(!full && !win));
    checkOutput("src1_ready", 64'(src1_ready), 64'(!full && win));
`ifndef RX_SCHED_TIMEOUT_EN
    checkOutput("err", 64'(err), 64'd0);
`endif

    push = !full && (win ? v1 : v0);
    pop  = m_valid && ordy;
    nb   = (m_busy & ~(dp ? dt : 4'b0000)) | (pop ? ht : 4'b0000);
    if (m_valid) nvalid = !pop;
    else nvalid = (sz > 0) && (cyc >= m_avail) && ((m_busy & ht) == 4'b0000);

    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(win ? i1 : i0);
    // After a pop the next head is examined on the following cycle; an
    // instruction landing in an empty queue waits one extra cycle.
    if (pop && mq.size() > 0) m_avail = cyc + 1;
    else if (push && sz == 0) m_avail = cyc + 2;
    if (push) m_rr = ~m_rr;
    m_busy  = nb;
    m_valid = nvalid;
    cyc++;
    @(posedge clk);
  endtask

  task automatic idleCycles(input int n, input logic ordy);
    for (int k = 0; k < n; k++)
      applyStimulus(1'b0, 64'd0, 1'b0, 64'd0, ordy, 1'b0, 4'b0000);
  endtask

  // Reset with every input active to show reset overrides them all.
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    src0_valid = 1'b1; src1_valid = 1'b1;
    out_ready = 1'b1; done_pulse = 1'b1; done_type = 4'hF;
    @(posedge clk);
    #1;
    checkOutput("rst_src0_ready", 64'(src0_ready), 64'd0);
    checkOutput("rst_src1_ready", 64'(src1_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_ins", out_ins, 64'd0);
    checkOutput("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    src0_valid = 1'b0; src1_valid = 1'b0;
    out_ready = 1'b0; done_pulse = 1'b0; done_type = 4'b0000;
    #1;
    checkOutput("rst_idle", 64'(idle), 64'd1);
    mq.delete();
    m_busy = 4'b0000; m_valid = 1'b0; m_rr = 1'b0;
    m_avail = 0; cyc = 0;
  endtask

  initial begin
    doReset();

    // Single RD_OP_D: two-cycle latency, busy d set on issue, cleared by done.
    insA = mkIns(OP_D);
    applyStimulus(1'b1, insA, 1'b0, 64'd0, 1'b1, 1'b0, 4'b0000);
    #1 checkOutput("lat_c1_valid", 64'(out_valid), 64'd0);
    idleCycles(1, 1'b1);
    #1 checkOutput("lat_c2_valid", 64'(out_valid), 64'd0);
    idleCycles(1, 1'b1);
    #1 checkOutput("lat_c3_valid", 64'(out_valid), 64'd1);
    checkOutput("lat_c3_ins", out_ins, insA);
    idleCycles(1, 1'b1);
    #1 checkOutput("d_busy_set", 64'(busy), 64'h4);
    applyStimulus(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 4'b0100);
    #1 checkOutput("d_busy_clr", 64'(busy), 64'd0);
    checkOutput("d_idle", 64'(idle), 64'd1);

    // Back-to-back RD_OP_DW: the second stalls until {i,p} complete.
    doReset();
    insA = mkIns(OP_DW);
    insB = mkIns(OP_DW);
    applyStimulus(1'b1, insA, 1'b0, 64'd0, 1'b1, 1'b0, 4'b0000);
    idleCycles(2, 1'b1);
    applyStimulus(1'b1, insB, 1'b0, 64'd0, 1'b1, 1'b0, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      idleCycles(1, 1'b1);
      #1 checkOutput("dw_stall", 64'(out_valid), 64'd0);
    end
    applyStimulus(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 4'b1010);
    #1 checkOutput("dw_after_done", 64'(out_valid), 64'd0);
    idleCycles(1, 1'b1);
    #1 checkOutput("dw_reissue", 64'(out_valid), 64'd1);
    checkOutput("dw_reissue_ins", out_ins, insB);
    idleCycles(1, 1'b1);
    applyStimulus(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 4'b1010);

    // Issue of RD_OP_G coinciding with a d completion: the set wins.
    doReset();
    insA = mkIns(OP_G);
    applyStimulus(1'b1, insA, 1'b0, 64'd0, 1'b0, 1'b0, 4'b0000);
    idleCycles(2, 1'b0);
    applyStimulus(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 4'b0100);
    #1 checkOutput("set_wins", 64'(busy[2]), 64'd1);

    // Both sources requesting every cycle: grants alternate, queue fills.
    doReset();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, mkIns(randOp()), 1'b1, mkIns(randOp()),
                    1'b0, 1'b0, 4'b0000);
    end
    #1 checkOutput("fill_cnt", 64'(fifo_cnt), 64'd4);
    checkOutput("fill_r0", 64'(src0_ready), 64'd0);
    checkOutput("fill_r1", 64'(src1_ready), 64'd0);
    for (int k = 0; k < 14; k++) begin
      applyStimulus(1'b1, mkIns(randOp()), 1'b1, mkIns(randOp()),
                    1'b1, 1'b1, 4'hF);
    end

    // Randomized traffic with a reset dropped into the middle of it.
    doReset();
    for (int k = 0; k < 800; k++) begin
      if (k == 400) doReset();
      applyStimulus(($urandom_range(0, 1) == 1), mkIns(randOp()),
                    ($urandom_range(0, 2) == 0), mkIns(randOp()),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) == 0), 4'($urandom_range(1, 15)));
    end

`ifdef RX_SCHED_TIMEOUT_EN
    // Watchdog: one instruction issued and never completed.
    doReset();
    applyStimulus(1'b1, mkIns(4'h7), 1'b0, 64'd0, 1'b1, 1'b0, 4'b0000);
    idleCycles(3, 1'b1);
    idleCycles(50, 1'b0);
    #1 checkOutput("wd_early", 64'(err), 64'd0);
    idleCycles(70, 1'b0);
    #1 checkOutput("wd_fired", 64'(err), 64'd1);
    idleCycles(20, 1'b0);
    #1 checkOutput("wd_sticky", 64'(err), 64'd1);
    doReset();
    checkOutput("wd_rst_err", 64'(err), 64'd0);
    checkOutput("wd_rst_cnt", 64'(fifo_cnt), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_ins_sched.md
RX_INS_SCHED -- requirements
Module: rx_ins_sched

Interface
REQ-001 Parameter INST_W, default 64, instruction width; opcode is bits [61:58].
REQ-002 Parameter FIFO_DEPTH, default 4, power of two, instruction queue depth.
REQ-003 Parameter TIMEOUT_CYC, default 65535, watchdog limit in cycles; used only with RX_SCHED_TIMEOUT_EN.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 src0_valid / src0_ready / src0_ins  in/out/in  1/1/INST_W  requester 0 (main instruction stream).
REQ-007 src1_valid / src1_ready / src1_ins  in/out/in  1/1/INST_W  requester 1 (prefetch stream).
REQ-008 out_valid / out_ready / out_ins  out/in/out  1/1/INST_W  issue port to the rx configuration stage.
REQ-009 done_pulse / done_type  in/in  1/4  completion from the rx configuration stage; type bits {i,d,p,a}.
REQ-010 busy  output  4  per-type outstanding flags {i,d,p,a}.
REQ-011 fifo_cnt  output  $clog2(FIFO_DEPTH)+1  queue occupancy.
REQ-012 idle  output  1  queue empty, no outstanding type, FSM in S_IDLE.
REQ-013 err  output  1  sticky watchdog error.

Function
REQ-014 Source arbitration: round-robin; the priority pointer toggles after every accepted push; with one source valid, that source wins.
REQ-015 srcN_ready is 1 only when the queue is not full and source N is the arbitration winner; at most one push per cycle.
REQ-016 Queue: FIFO_DEPTH entries, wrap-around read/write pointers with extra wrap bit; full = FIFO_DEPTH entries, empty = 0.
REQ-017 Type map: opcode RD_OP_DW -> i (bit3); RD_OP_D or RD_OP_G -> d (bit2); all other opcodes -> a (bit0); bit1 (p) is set with bit3 for RD_OP_DW.
REQ-018 FSM states: S_IDLE, S_CHECK, S_ISSUE.
REQ-019 S_IDLE -> S_CHECK when the queue is non-empty.
REQ-020 S_CHECK -> S_ISSUE when (busy & head_type) == 0; otherwise stays in S_CHECK (hazard stall).
REQ-021 In S_ISSUE: out_valid=1, out_ins = queue head; out_ins stable while out_valid=1 and out_ready=0.
REQ-022 On out_valid & out_ready: pop head, set busy |= head_type, then go to S_CHECK if the queue still holds an entry after the pop, else S_IDLE.
REQ-023 Latency: push into an empty queue with no hazard -> out_valid asserted 2 cycles later.
REQ-024 done_pulse clears busy bits selected by done_type; done_type bits not set in busy are ignored.
REQ-025 Issue and done for the same type in one cycle: the set wins; busy bit ends at 1.
REQ-026 Push and pop in the same cycle when the queue is full: the push is accepted only if ready was already high, which it is not when full; the pop frees the slot for the next cycle.
REQ-027 fifo_cnt is updated in the cycle after each push or pop; a simultaneous push and pop leaves it unchanged.

Reset
REQ-028 With rst_n=0 at a clock edge:
- FSM goes to S_IDLE.
- Pointers, fifo_cnt, busy and err are cleared; the arbitration pointer is set to source 0.
- out_valid=0, src0_ready=0, src1_ready=0; out_ins is reset to 0.
REQ-029 Reset mid-transaction discards queued and in-flight instructions; no done_pulse is expected afterwards.
REQ-030 idle=1 on the first cycle after reset.

Configuration
REQ-031 Macro RX_SCHED_TIMEOUT_EN.
- Defined: a 16-bit counter increments while busy != 0 and no done_pulse is present; it clears on done_pulse or when busy == 0.
- Defined: when the counter reaches TIMEOUT_CYC, err is set and held until reset.
- Not defined: no counter exists and err is tied to 0.

Verification
REQ-032 Push RD_OP_D on src0 into an empty queue, out_ready=1 -> out_valid at cycle+2, busy=4'b0100; done_pulse with done_type=4'b0100 -> busy=0, idle=1.
REQ-033 Issue RD_OP_DW, then queue RD_OP_DW -> the second stalls in S_CHECK with out_valid=0 until done_type=4'b1010, then issues 2 cycles later.
REQ-034 src0 and src1 both valid every cycle -> grants alternate 0,1,0,1; the queue fills at 4 entries and both readys stay 0 until a pop.
REQ-035 In the issue cycle of an RD_OP_G, drive done_type=4'b0100 -> busy[2] remains 1.
REQ-036 With RX_SCHED_TIMEOUT_EN defined and TIMEOUT_CYC=100: issue one instruction, send no done -> err=1 after 100 cycles and stays 1; pulse rst_n low -> err=0, fifo_cnt=0.
